// File: rtl/instruction_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module      : instruction_fetch_unit
//  Description : Front end of the multicycle CPU. Owns the program counter,
//                fetches two-byte instructions (IR1, IR2) from instruction
//                memory over a req/ack handshake, and applies jump loads
//                requested by the control unit.
//  Revision    : 1.0 - initial release
// ============================================================================
module instruction_fetch_unit #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int RESET_PC   = 0,
    parameter int TIMEOUT    = 15
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  IR1Enable,
    input  logic                  IR2Enable,
    input  logic                  PCEnable,
    input  logic                  PCSelect,
    input  logic [ADDR_WIDTH-1:0] jumpTarget,
    output logic                  memReq,
    output logic [ADDR_WIDTH-1:0] memAddr,
    input  logic [DATA_WIDTH-1:0] memRdata,
    input  logic                  memAck,
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [DATA_WIDTH-1:0] ir1,
    output logic [DATA_WIDTH-1:0] ir2,
    output logic [3:0]            opcode,
    output logic                  fetchBusy,
    output logic                  instrValid,
    output logic                  fetchError
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ1 = 2'd1;
    localparam logic [1:0] S_REQ2 = 2'd2;
    localparam logic [1:0] S_ERR  = 2'd3;

    localparam logic [ADDR_WIDTH-1:0] C_RESET_PC     = ADDR_WIDTH'(RESET_PC);
    localparam logic [ADDR_WIDTH-1:0] C_PC_STEP      = ADDR_WIDTH'(1);
    localparam logic [7:0]            C_TIMEOUT_LAST = 8'(TIMEOUT - 1);

    logic [1:0]            state;
    logic                  pend_ir1;
    logic                  pend_ir2;
    logic                  pend_jump;
    logic [ADDR_WIDTH-1:0] jump_addr;
    logic [7:0]            timeout_cnt;

    logic                  jump_now;
    logic                  in_req;
    logic                  ack_ok;

    // Command decode: an ack only counts once the request is actually on the bus.
    assign jump_now  = PCEnable & PCSelect;
    assign in_req    = (state == S_REQ1) || (state == S_REQ2);
    assign ack_ok    = in_req & memReq & memAck;
    assign opcode    = ir1[DATA_WIDTH-1:DATA_WIDTH-4];
    assign fetchBusy = (state != S_IDLE);

    // Fetch sequencer, PC, instruction registers and bus request in one place,
    // since every transition touches several of them together.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            state       <= S_IDLE;
            pc          <= C_RESET_PC;
            ir1         <= '0;
            ir2         <= '0;
            memReq      <= 1'b0;
            memAddr     <= '0;
            instrValid  <= 1'b0;
            fetchError  <= 1'b0;
            pend_ir1    <= 1'b0;
            pend_ir2    <= 1'b0;
            pend_jump   <= 1'b0;
            jump_addr   <= '0;
            timeout_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    timeout_cnt <= '0;
                    // A fresh jump sample is newer than a held one, so it wins.
                    if (pend_jump || jump_now) begin
                        pc         <= jump_now ? jumpTarget : jump_addr;
                        instrValid <= 1'b0;
                        pend_jump  <= 1'b0;
                    end
                    if (pend_ir1 || IR1Enable) begin
                        state    <= S_REQ1;
                        pend_ir1 <= 1'b0;
                        pend_ir2 <= pend_ir2 | IR2Enable;
                    end else if (pend_ir2 || IR2Enable) begin
                        state    <= S_REQ2;
                        pend_ir2 <= 1'b0;
                    end
                end

                S_REQ1, S_REQ2: begin
                    // Commands arriving mid-fetch are queued; duplicates collapse.
                    if (IR1Enable) pend_ir1 <= 1'b1;
                    if (IR2Enable) pend_ir2 <= 1'b1;
                    if (jump_now) begin
                        pend_jump <= 1'b1;
                        jump_addr <= jumpTarget;
                    end
                    if (ack_ok) begin
                        memReq      <= 1'b0;
                        pc          <= pc + C_PC_STEP;
                        timeout_cnt <= '0;
                        if (state == S_REQ1) begin
                            ir1        <= memRdata;
                            instrValid <= 1'b0;
                        end else begin
                            ir2        <= memRdata;
                            instrValid <= 1'b1;
                        end
                        // A queued IR2 chains straight on from an IR1 fetch.
                        if ((state == S_REQ1) && (pend_ir2 || IR2Enable)) begin
                            state    <= S_REQ2;
                            pend_ir2 <= 1'b0;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else begin
                        if (!memReq) begin
                            memReq  <= 1'b1;
                            memAddr <= pc;
                        end
                        if (timeout_cnt == C_TIMEOUT_LAST) begin
                            state       <= S_ERR;
                            memReq      <= 1'b0;
                            timeout_cnt <= '0;
                        end else begin
                            timeout_cnt <= timeout_cnt + 8'd1;
                        end
                    end
                end

                S_ERR: begin
                    // Abandon queued fetches but keep a queued jump for IDLE.
                    fetchError <= 1'b1;
                    memReq     <= 1'b0;
                    pend_ir1   <= 1'b0;
                    pend_ir2   <= 1'b0;
                    if (jump_now) begin
                        pend_jump <= 1'b1;
                        jump_addr <= jumpTarget;
                    end
                    state <= S_IDLE;
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Front end of the multicycle CPU, directly upstream of the control unit.
- Owns the program counter and fetches each two-byte instruction from instruction memory over a req/ack handshake. The first byte goes to IR1 (opcode and register field) and the second to IR2 (address or immediate).
- Presents the opcode to the control unit and applies jump-target loads.
- Fetch and PC-load commands come from the control unit's enable/select strobes.

Parameters:
ADDR_WIDTH, 8, PC and memory address width
DATA_WIDTH, 8, instruction byte width; opcode is the top 4 bits of IR1
RESET_PC, 0, PC value after reset
TIMEOUT, 15, max cycles waiting for memAck before aborting a fetch (1..255)

Ports:
clock  in  1  single clock, rising edge
resetN  in  1  asynchronous, active-low reset
IR1Enable  in  1  fetch-first-byte command, sampled at rising edge
IR2Enable  in  1  fetch-second-byte command, sampled at rising edge
PCEnable  in  1  PC load strobe (only acted on when PCSelect=1)
PCSelect  in  1  1: PCEnable loads PC from jumpTarget
jumpTarget  in  ADDR_WIDTH  branch target (IR2 value routed by datapath)
memReq  out  1  read request to instruction memory
memAddr  out  ADDR_WIDTH  read address, stable while memReq=1
memRdata  in  DATA_WIDTH  read data, valid with memAck
memAck  in  1  one-cycle read completion
pc  out  ADDR_WIDTH  current program counter
ir1  out  DATA_WIDTH  first instruction byte
ir2  out  DATA_WIDTH  second instruction byte
opcode  out  4  ir1[DATA_WIDTH-1:DATA_WIDTH-4], combinational from ir1
fetchBusy  out  1  1 whenever state != IDLE
instrValid  out  1  both bytes of the current instruction fetched
fetchError  out  1  sticky memory timeout flag

Behaviour:
- Reset (resetN=0, asynchronous): pc=RESET_PC; ir1=ir2=0; memReq=0; memAddr=0; fetchBusy=0; instrValid=0; fetchError=0; state=IDLE; pending flags and timeout counter cleared. Applies mid-fetch; a memAck arriving after reset release while in IDLE is ignored.
- States:
  - IDLE
  - REQ1: fetch IR1
  - REQ2: fetch IR2
  - ERR: one cycle
- IDLE, in priority order:
  - A pending jump or a (PCEnable & PCSelect) sample loads pc<=jumpTarget. It takes effect before any fetch started in the same cycle, so that fetch uses the new pc one cycle later.
  - Pending IR1 or IR1Enable -> REQ1.
  - Else pending IR2 or IR2Enable -> REQ2.
- IR1Enable and IR2Enable high together in IDLE: go to REQ1 and latch IR2 as pending; REQ2 follows immediately after REQ1 completes.
- Commands sampled while busy:
  - IR1Enable/IR2Enable set the corresponding pending flag. Duplicates collapse to one.
  - PCEnable&PCSelect latches a pending jump with its jumpTarget value; a later one overwrites it. It is applied on the first cycle back in IDLE.
- REQ1/REQ2:
  - memReq=1 and memAddr=pc, both registered and asserted the cycle after entry.
  - Counter increments each cycle without memAck.
  - On memAck: the byte register <= memRdata; pc<=pc+1 modulo 2^ADDR_WIDTH (2^ADDR_WIDTH-1 wraps to 0); memReq drops next cycle; return to IDLE (or REQ2 if IR2 pending).
  - Best-case latency with memAck one cycle after memReq: 3 cycles from command sample to byte register update.
- REQ1 completion clears instrValid. REQ2 completion sets instrValid=1. instrValid also clears on a PC jump load.
- Timeout: when the counter reaches TIMEOUT with no ack, go to ERR. In ERR: memReq=0, fetchError=1, the byte register and pc are unchanged, all pending fetch flags are cleared, and the pending jump is kept. Then return to IDLE. fetchError clears only on reset.
- memAck outside REQ1/REQ2 is ignored.
- PCEnable with PCSelect=0 is ignored; pc advances only through fetch completion.

Test Plan:
- Reset with RESET_PC=0x10, then pulse IR1Enable; memory acks 1 cycle after req with 0x5A -> memAddr=0x10, ir1=0x5A, opcode=0x5, pc=0x11, instrValid=0.
- IR1Enable and IR2Enable together, memory returns 0x82 then 0x3C -> ir1=0x82, ir2=0x3C, opcode=0x8, pc advanced by 2, instrValid=1, fetchBusy high throughout.
- PCEnable=PCSelect=1, jumpTarget=0x40, issued during a REQ2 wait -> pc unchanged until REQ2 completes, then 0x40; next IR1 fetch uses memAddr=0x40; instrValid=0 after the load.
- pc=0xFF with ADDR_WIDTH=8, fetch one byte -> pc=0x00.
- memAck withheld 15 cycles in REQ1 -> ERR, fetchError=1 sticky, ir1 and pc unchanged, memReq=0; a later fetch succeeds and fetchError stays 1.
- resetN driven low while memReq=1 -> memReq=0 and pc=RESET_PC immediately; a memAck one cycle after release leaves ir1=0.
